data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Bus-side data memory that serves the load/store traffic issued by the RV32I datapath, acting as the responder to the core's `busWe`/`store_size` request interface. It accepts one request at a time and performs byte/half/word stores with per-lane write enables. It returns load data sign- or zero-extended per the load funct3, and answers every request with a one-cycle `busReady` pulse after fixed latency. Misalignment checking is a compile-time option.

## Interface
- `ADDR_WIDTH`, default 8: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `busReq` input 1: request valid; level, held by the requester until it samples `busReady`=1.
- `busWe` input 1: 1 = store, 0 = load; sampled at accept.
- `busAddr` input 32: byte address; bits [ADDR_WIDTH+1:2] select the word; higher bits ignored (wrap).
- `busWData` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `store_size` input 2: 00 byte, 01 half, 10 word, 11 invalid.
- `load_funct3` input 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others invalid.
- `busReady` output 1: one-cycle response pulse.
- `busRData` output 32: extended load data; valid only while `busReady`=1 for a load.
- `busErr` output 1: error flag, qualified by `busReady`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS when `busReq`=1. Capture `busWe`, `busAddr`, `busWData`, `store_size`, `load_funct3` into request registers. Inputs may change after accept.
- ACCESS → RESP unconditionally:
  - Store: on the edge leaving ACCESS, write the shifted data to the lanes in `byteEn`.
    - Byte: lane `addr[1:0]`.
    - Half: lanes {addr[1],0} and {addr[1],1}.
    - Word: all four lanes.
  - Load: read the whole addressed word into the read register.
- RESP → IDLE unconditionally.
  - `busReady`=1 for this cycle only.
  - For a load, `busRData` = selected byte/half/word, shifted down and extended. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - For a store, `busRData`=0.
- If `busReq` is still 1 in the IDLE cycle after RESP, it is a new request. Requesters deassert on the edge where they sample `busReady`=1.
- `busReq` is ignored in ACCESS and RESP.
- Invalid `store_size` (11) or invalid `load_funct3`: behaviour is set by the macro (see Configuration).
- Memory contents are not reset and are undefined at power-up.

## Timing
- Accept at edge T, in IDLE with `busReq`=1. ACCESS runs in cycle T..T+1; RESP (`busReady`=1) in cycle T+1..T+2.
- Fixed latency of 2 cycles from accept to response, identical for loads and stores.
- Throughput is one request per 3 cycles.
- A store is visible to a load accepted in the cycle after the store's RESP.
- `busReady`, `busRData` and `busErr` are registered outputs, driven directly from flops.
- Reset values: state IDLE, `busReady`=0, `busRData`=0, `busErr`=0, request registers 0.
- Reset asserted while in ACCESS aborts the request: no memory write occurs and no `busReady` is issued. Reset in RESP drops the pulse immediately.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - These requests are errors: half with addr[0]=1, word with addr[1:0]≠0, `store_size`=11, invalid `load_funct3`.
  - An error request runs the same FSM and latency.
  - No lane is written and `busRData`=0.
  - `busErr`=1 together with `busReady`.
- `MISALIGN_CHECK_EN` undefined:
  - `busErr` is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - `store_size`=11 is treated as word. Invalid `load_funct3` is treated as LW.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `busRData`=0xDEADBEEF. `busReady` is high exactly 2 cycles after each accept, for 1 cycle.
- SW 0x11223344 @0x20; SB 0x000000AA @0x22; LW @0x20 → 0x11AA3344.
- Word 0x0000_8080 @0x30: LB @0x30 → 0xFFFFFF80; LBU @0x30 → 0x00000080; LH @0x30 → 0xFFFF8080; LHU @0x30 → 0x00008080.
- With `MISALIGN_CHECK_EN`: SW 0x12345678 @0x41 → `busErr`=1 with `busReady`; LW @0x40 still returns its prior value. Without the macro, the same store writes word 0x40 and `busErr`=0.
- `busReq` held high continuously → accepts at IDLE cycles only, one `busReady` per 3 cycles, no extra writes.
- SW 0xCAFEF00D @0x50 with `reset` pulsed during ACCESS → no `busReady`; after reset, LW @0x50 returns the pre-store value; all outputs are 0 while `reset`=1.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 32-bit data memory answering the core's load/store bus.
// One request at a time; fixed 2-cycle accept-to-response latency (IDLE -> ACCESS -> RESP).
// Stores write byte/half/word lanes. Loads return the selected data, sign- or zero-extended.
//
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned or invalid requests on busErr.
// Such requests write nothing and return zero data. Without the macro, busErr is tied low:
// half ignores addr[0], word ignores addr[1:0], store_size 11 acts as word, and an invalid
// load_funct3 acts as LW.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   busReq              request valid (level, held until busReady is sampled)
//   busWe               1 = store, 0 = load
//   busAddr             byte address; bits [ADDR_WIDTH+1:2] select the word
//   busWData            right-aligned store data
//   store_size          00 byte, 01 half, 10 word
//   load_funct3         LB/LH/LW/LBU/LHU encoding
//   busReady            one-cycle response pulse
//   busRData            extended load data (zero for stores and errors)
//   busErr              error flag, qualified by busReady
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [1:0]  store_size,
  input  logic [2:0]  load_funct3,
  output logic        busReady,
  output logic [31:0] busRData,
  output logic        busErr
);

  localparam int unsigned AW = ADDR_WIDTH + 2;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;
  logic [2:0]      funct3_q;

  logic [31:0]     mem_q [2**ADDR_WIDTH];

  logic [1:0]      acc_size;
  logic            acc_uns;
  logic            invalid;
  logic            misaligned;
  logic            err;
  logic [3:0]      byte_en;
  logic [31:0]     wlane;
  logic [31:0]     rd_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     rdata_d;

  // Address bits above the memory window wrap and are not used.
  logic unused_addr;
  assign unused_addr = ^busAddr[31:AW];

  // Decode access size, signedness and validity from the captured request.
  always_comb begin
    acc_size = SzWord;
    acc_uns  = 1'b0;
    invalid  = 1'b0;
    if (we_q) begin
      unique case (size_q)
        2'b00:   acc_size = SzByte;
        2'b01:   acc_size = SzHalf;
        2'b10:   acc_size = SzWord;
        default: invalid  = 1'b1;
      endcase
    end else begin
      unique case (funct3_q)
        3'b000:  acc_size = SzByte;
        3'b001:  acc_size = SzHalf;
        3'b010:  acc_size = SzWord;
        3'b100:  begin acc_size = SzByte; acc_uns = 1'b1; end
        3'b101:  begin acc_size = SzHalf; acc_uns = 1'b1; end
        default: invalid  = 1'b1;
      endcase
    end
    misaligned = ((acc_size == SzHalf) && addr_q[0]) ||
                 ((acc_size == SzWord) && (addr_q[1:0] != 2'b00));
  end

`ifdef MISALIGN_CHECK_EN
  assign err = invalid | misaligned;
`else
  logic unused_chk;
  assign unused_chk = invalid ^ misaligned;
  assign err = 1'b0;
`endif

  // Store lane enables and lane-replicated write data.
  always_comb begin
    byte_en = 4'b1111;
    wlane   = wdata_q;
    unique case (acc_size)
      SzByte: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wlane   = {4{wdata_q[7:0]}};
      end
      SzHalf: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load data selection and extension.
  always_comb begin
    rd_word = mem_q[addr_q[AW-1:2]];
    unique case (addr_q[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (acc_size)
      SzByte:  rdata_d = {{24{ld_byte[7] & ~acc_uns}}, ld_byte};
      SzHalf:  rdata_d = {{16{ld_half[15] & ~acc_uns}}, ld_half};
      default: rdata_d = rd_word;
    endcase
    if (we_q || err) rdata_d = 32'h0;
  end

  // Memory is not reset; a reset during ACCESS moves state_q to IDLE before the edge,
  // which suppresses the write.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[addr_q[AW-1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      funct3_q <= 3'b000;
      busReady <= 1'b0;
      busRData <= 32'h0;
      busErr   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          busReady <= 1'b0;
          busRData <= 32'h0;
          busErr   <= 1'b0;
          if (busReq) begin
            we_q     <= busWe;
            addr_q   <= busAddr[AW-1:0];
            wdata_q  <= busWData;
            size_q   <= store_size;
            funct3_q <= load_funct3;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          busReady <= 1'b1;
          busRData <= rdata_d;
          busErr   <= err;
          state_q  <= StResp;
        end
        StResp: begin
          busReady <= 1'b0;
          busRData <= 32'h0;
          busErr   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder with hand-computed expected values.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [1:0]  store_size;
  logic [2:0]  load_funct3;
  logic        busReady;
  logic [31:0] busRData;
  logic        busErr;

  int n_vec;
  int n_err;

  data_mem_responder #(.ADDR_WIDTH(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .busReq      (busReq),
    .busWe       (busWe),
    .busAddr     (busAddr),
    .busWData    (busWData),
    .store_size  (store_size),
    .load_funct3 (load_funct3),
    .busReady    (busReady),
    .busRData    (busRData),
    .busErr      (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One bus transaction, started at a negedge with the DUT idle. Scrambles inputs after
  // accept, checks latency 2 and a single-cycle busReady pulse, returns data and error.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] sz, input logic [2:0] f3,
                      output logic [31:0] rd, output logic er);
    int lat;
    int nready;
    lat    = 0;
    nready = 0;
    rd     = 32'h0;
    er     = 1'b0;
    busReq      = 1'b1;
    busWe       = we;
    busAddr     = addr;
    busWData    = wdata;
    store_size  = sz;
    load_funct3 = f3;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busReq      = 1'b0;
        busWe       = ~we;
        busAddr     = 32'hFFFF_FFFF;
        busWData    = 32'h5A5A_5A5A;
        store_size  = ~sz;
        load_funct3 = ~f3;
      end
      if (busReady) begin
        nready++;
        if (lat == 0) begin
          lat = k;
          rd  = busRData;
          er  = busErr;
        end
      end
    end
    check("latency", lat, 2);
    check("pulse_width", nready, 1);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sz, output logic er);
    logic [31:0] rd;
    xfer(1'b1, addr, wdata, sz, 3'b000, rd, er);
    check("store_rdata", rd, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    xfer(1'b0, addr, 32'h0, 2'b00, f3, rd, er);
    check(tag, rd, exp_d);
    check({tag, "_err"}, {31'h0, er}, {31'h0, exp_e});
  endtask

  logic er;
  int   cnt;
  int   pos_sum;
  logic exp_mis;

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef MISALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    reset = 1'b1;
    busReq = 1'b0; busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0;
    store_size = 2'b00; load_funct3 = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, busReady}, 32'h0);
    check("rst_rdata", busRData, 32'h0);
    check("rst_err", {31'h0, busErr}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Word store / load.
    store(32'h10, 32'hDEAD_BEEF, 2'b10, er);
    check("sw10_err", {31'h0, er}, 32'h0);
    load_chk("lw10", 32'h10, 3'b010, 32'hDEAD_BEEF, 1'b0);

    // Byte merge into a word.
    store(32'h20, 32'h1122_3344, 2'b10, er);
    store(32'h22, 32'h1234_56AA, 2'b00, er);
    load_chk("lw20", 32'h20, 3'b010, 32'h11AA_3344, 1'b0);

    // Sign/zero extension.
    store(32'h30, 32'h0000_8080, 2'b10, er);
    load_chk("lb30", 32'h30, 3'b000, 32'hFFFF_FF80, 1'b0);
    load_chk("lbu30", 32'h30, 3'b100, 32'h0000_0080, 1'b0);
    load_chk("lh30", 32'h30, 3'b001, 32'hFFFF_8080, 1'b0);
    load_chk("lhu30", 32'h30, 3'b101, 32'h0000_8080, 1'b0);
    store(32'h32, 32'h7777_BEEF, 2'b01, er);
    load_chk("lw30_sh", 32'h30, 3'b010, 32'hBEEF_8080, 1'b0);
    load_chk("lh32", 32'h32, 3'b001, 32'hFFFF_BEEF, 1'b0);
    load_chk("lbu33", 32'h33, 3'b100, 32'h0000_00BE, 1'b0);
    load_chk("lb31", 32'h31, 3'b000, 32'hFFFF_FF80, 1'b0);

    // Misaligned word store.
    store(32'h40, 32'h0102_0304, 2'b10, er);
    store(32'h41, 32'h1234_5678, 2'b10, er);
    check("sw41_err", {31'h0, er}, {31'h0, exp_mis});
    load_chk("lw40", 32'h40, 3'b010, exp_mis ? 32'h0102_0304 : 32'h1234_5678, 1'b0);

    // Invalid store size and invalid load funct3.
    store(32'h44, 32'h0000_0000, 2'b10, er);
    store(32'h44, 32'hA5A5_A5A5, 2'b11, er);
    check("ss11_err", {31'h0, er}, {31'h0, exp_mis});
    load_chk("lw44", 32'h44, 3'b010, exp_mis ? 32'h0 : 32'hA5A5_A5A5, 1'b0);
    load_chk("f3_011", 32'h44, 3'b011, exp_mis ? 32'h0 : 32'hA5A5_A5A5, exp_mis);

    // busReq held high: one response every third cycle.
    busReq = 1'b1; busWe = 1'b0; busAddr = 32'h10; load_funct3 = 3'b010;
    cnt = 0;
    pos_sum = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (busReady) begin
        cnt++;
        pos_sum += k;
        check("held_rdata", busRData, 32'hDEAD_BEEF);
      end
      if (k == 11) busReq = 1'b0;
    end
    check("held_count", cnt, 4);
    check("held_spacing", pos_sum, 26);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busReady) cnt++;
    end
    check("held_after", cnt, 0);

    // Reset during ACCESS aborts the store.
    store(32'h50, 32'h0BAD_F00D, 2'b10, er);
    busReq = 1'b1; busWe = 1'b1; busAddr = 32'h50; busWData = 32'hCAFE_F00D;
    store_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    busReq = 1'b0;
    #1;
    check("abort_ready", {31'h0, busReady}, 32'h0);
    @(negedge clk);
    check("inrst_ready", {31'h0, busReady}, 32'h0);
    check("inrst_rdata", busRData, 32'h0);
    check("inrst_err", {31'h0, busErr}, 32'h0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busReady) cnt++;
    end
    check("abort_noready", cnt, 0);
    load_chk("lw50", 32'h50, 3'b010, 32'h0BAD_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
